// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
// It applies branch-unit redirects and load-use stalls to PC, and drives the
// IF/ID enable and the IF/ID and ID/EX flushes. It also runs the
// halt -> drain -> resume sequence and keeps saturating redirect and stall
// counters. This block is the only writer of PC.
module pc_sequencer #(
   parameter int PC_W         = 9,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             Stall,
   input  logic             Halt_req,
   input  logic             Resume,
   output logic [PC_W-1:0]  PC,
   output logic             IfId_Write,
   output logic             IfId_Flush,
   output logic             IdEx_Flush,
   output logic             Halted,
   output logic             Misalign_Err,
   output logic [CNT_W-1:0] Redirect_Cnt,
   output logic [CNT_W-1:0] Stall_Cnt
);

   // A drain length of zero would skip the drain entirely, so it is treated as one.
   localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
   localparam int DCNT_W    = $clog2(DRAIN_EFF + 1);

   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_EFF);
   localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
   localparam logic [PC_W-1:0]   PC_STEP    = PC_W'(4);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DCNT_W-1:0] drain_cnt;
   logic [DCNT_W-1:0] drain_cnt_nxt;
   logic [PC_W-1:0]   pc_nxt;
   logic [PC_W-1:0]   redir_target;
   logic              redir;
   logic              stl;
   logic              misalign;
   logic              unused_brpc_hi;

   // A redirect always wins over a stall, because the stalled ID instruction
   // is on the wrong path. Nothing acts while the core is halted.
   assign redir = PcSel && (state != ST_HALT);
   assign stl   = Stall && !redir && (state != ST_HALT);

   // Targets are forced to word alignment. A misaligned target is still taken,
   // and it is also reported through the sticky error flag.
   assign redir_target = {BrPC[PC_W-1:2], 2'b00};
   assign misalign     = redir && (BrPC[1:0] != 2'b00);

   // PC is narrower than the branch unit's target bus. The upper bits are
   // dropped on purpose.
   assign unused_brpc_hi = ^BrPC[31:PC_W];

   // State register and drain counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         // NOTE: every clocked assignment uses <= so that all registers sample
         // the pre-edge values of their inputs, whatever the statement order.
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   // Next-state logic: RUN -> DRAIN -> HALT -> RUN.
   always_comb begin
      // NOTE: each signal gets a default first, so no path through the case
      // can leave it unassigned and infer a latch.
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      unique case (state)
         ST_RUN: begin
            // If Halt_req and Resume arrive together in RUN, Halt_req wins.
            // Resume has no meaning in RUN.
            if (Halt_req) begin
               state_nxt     = ST_DRAIN;
               drain_cnt_nxt = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            // Only non-stalled cycles retire work, so a stall freezes the count.
            // Redirects and a repeated Halt_req do not restart the count.
            if (!Stall) begin
               drain_cnt_nxt = drain_cnt - DCNT_ONE;
               if (drain_cnt == DCNT_ONE) begin
                  state_nxt = ST_HALT;
               end
            end
         end
         ST_HALT: begin
            if (Resume) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt     = ST_RUN;
            drain_cnt_nxt = '0;
         end
      endcase
   end

   // Output decode from the state and the redirect/stall terms.
   always_comb begin
      IfId_Write = 1'b0;
      IfId_Flush = 1'b0;
      IdEx_Flush = 1'b0;
      Halted     = 1'b0;
      unique case (state)
         ST_RUN: begin
            IfId_Write = !stl;
            IfId_Flush = redir;
            IdEx_Flush = redir || stl;
         end
         ST_DRAIN: begin
            IfId_Flush = 1'b1;
            IdEx_Flush = redir || stl;
         end
         ST_HALT: begin
            Halted = 1'b1;
         end
         default: begin
            IfId_Write = 1'b0;
         end
      endcase
   end

   // Next fetch address. The order of priority is redirect, then stall hold,
   // then sequential step. PC does not step outside RUN.
   always_comb begin
      pc_nxt = PC;
      if (redir) begin
         pc_nxt = redir_target;
      end else if ((state == ST_RUN) && !stl) begin
         pc_nxt = PC + PC_STEP;
      end
   end

   // Program counter register. It wraps modulo 2^PC_W.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC <= '0;
      end else begin
         PC <= pc_nxt;
      end
   end

   // Sticky misaligned-target flag. Only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Misalign_Err <= 1'b0;
      end else if (misalign) begin
         Misalign_Err <= 1'b1;
      end
   end

   // Saturating count of redirects that were taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Redirect_Cnt <= '0;
      end else if (redir && (Redirect_Cnt != CNT_MAX)) begin
         Redirect_Cnt <= Redirect_Cnt + CNT_ONE;
      end
   end

   // Saturating count of cycles in which a stall was applied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Stall_Cnt <= '0;
      end else if (stl && (Stall_Cnt != CNT_MAX)) begin
         Stall_Cnt <= Stall_Cnt + CNT_ONE;
      end
   end

endmodule
